// File: rtl/multicycle_shift_unit.sv
// multicycle_shift_unit
// Iterative shift/rotate unit that sits beside the ALU. An operation is
// accepted with START in IDLE, shifted STEP bit positions per cycle in SHIFT,
// and reported with a one-cycle DONE pulse from DONE_S. The control unit
// stalls while BUSY is high and captures RESULT when DONE is high.
//
// Ports
//   CLK      rising-edge clock
//   RESET    synchronous active-high reset; abandons any operation
//   START    operation request, sampled only in IDLE
//   MODE     00=SLL 01=SRL 10=SRA 11=ROR, sampled with START
//   DATA_IN  WIDTH-bit operand, sampled with START
//   SHAMT    SHW-bit unsigned shift amount, sampled with START
//   BUSY     high whenever the unit is not in IDLE
//   DONE     one-cycle pulse, RESULT valid
//   RESULT   WIDTH-bit result, held until the next DONE
module multicycle_shift_unit #(
  parameter int WIDTH = 8,
  parameter int SHW   = 8,
  parameter int STEP  = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic [SHW-1:0]   SHAMT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  localparam int LW = $clog2(WIDTH);       // bits of a rotate amount
  localparam int CW = $clog2(WIDTH) + 1;   // count must hold WIDTH itself
  localparam int AW = (SHW > CW) ? SHW : CW;

  typedef enum logic [1:0] {
    M_SLL = 2'b00,
    M_SRL = 2'b01,
    M_SRA = 2'b10,
    M_ROR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [CW-1:0]    n_eff;
  logic [CW-1:0]    step_k;
  logic [WIDTH-1:0] shifted;

  // Shifts saturate at WIDTH positions; rotates wrap modulo WIDTH.
  function automatic logic [CW-1:0] eff_count(input logic [1:0] m,
                                               input logic [SHW-1:0] amt);
    logic [AW-1:0] a;
    a = AW'(amt);
    if (m == M_ROR)
      return CW'(a[LW-1:0]);
    else if (a >= AW'(WIDTH))
      return CW'(WIDTH);
    else
      return CW'(a);
  endfunction

  // One bit position in the given mode. SRA keeps the current MSB, which
  // never changes during an SRA operation, so it is the latched sign bit.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] d,
                                              input logic [1:0] m);
    case (m)
      M_SLL:   return {d[WIDTH-2:0], 1'b0};
      M_SRL:   return {1'b0, d[WIDTH-1:1]};
      M_SRA:   return {d[WIDTH-1], d[WIDTH-1:1]};
      default: return {d[0], d[WIDTH-1:1]};
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    n_eff    = eff_count(MODE, SHAMT);
    step_k   = '0;
    shifted  = data_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          data_d = DATA_IN;
          mode_d = MODE;
          cnt_d  = n_eff;
          if (n_eff == '0) begin
            // Nothing to shift: RESULT is the operand, loaded on entry to DONE_S.
            state_d  = S_DONE;
            result_d = DATA_IN;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end

      S_SHIFT: begin
        step_k = (cnt_q < CW'(STEP)) ? cnt_q : CW'(STEP);
        for (int i = 0; i < STEP; i++) begin
          if (CW'(i) < step_k)
            shifted = shift1(shifted, mode_q);
        end
        data_d = shifted;
        cnt_d  = cnt_q - step_k;
        if (cnt_d == '0) begin
          // RESULT is registered, so load it on the way into DONE_S.
          state_d  = S_DONE;
          result_d = shifted;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      mode_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Outputs decode only registered state.
  assign BUSY   = (state_q != S_IDLE);
  assign DONE   = (state_q == S_DONE);
  assign RESULT = result_q;

endmodule

// File: tb/tb_multicycle_shift_unit.sv
module tb_multicycle_shift_unit;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start4;
  logic [1:0] mode;
  logic [7:0] din;
  logic [7:0] shamt;
  logic       busy1, done1, busy4, done4;
  logic [7:0] res1, res4;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] last1 = 8'h00;
  logic [7:0] last4 = 8'h00;

  always #5 clk = ~clk;

  multicycle_shift_unit #(.WIDTH(8), .SHW(8), .STEP(1)) u_dut1 (
    .CLK(clk), .RESET(rst), .START(start1), .MODE(mode), .DATA_IN(din),
    .SHAMT(shamt), .BUSY(busy1), .DONE(done1), .RESULT(res1)
  );

  multicycle_shift_unit #(.WIDTH(8), .SHW(8), .STEP(4)) u_dut4 (
    .CLK(clk), .RESET(rst), .START(start4), .MODE(mode), .DATA_IN(din),
    .SHAMT(shamt), .BUSY(busy4), .DONE(done4), .RESULT(res4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic get_busy(input int which);
    return (which == 4) ? busy4 : busy1;
  endfunction

  function automatic logic get_done(input int which);
    return (which == 4) ? done4 : done1;
  endfunction

  function automatic logic [7:0] get_res(input int which);
    return (which == 4) ? res4 : res1;
  endfunction

  // Present an operation in cycle 0; returns just after the accepting edge.
  task automatic start_op(input int which, input logic [1:0] m, input logic [7:0] d,
                          input logic [7:0] s);
    @(negedge clk);
    mode = m; din = d; shamt = s;
    if (which == 4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0; start4 = 1'b0;
  endtask

  // Cycle of the first DONE (-1 on timeout); BUSY must be high and RESULT
  // must hold its previous value in every cycle before it.
  task automatic wait_done(input int which, input logic [7:0] hold, output int cyc,
                           output logic busy_ok, output logic hold_ok);
    cyc = -1; busy_ok = 1'b1; hold_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (get_busy(which) !== 1'b1) busy_ok = 1'b0;
      if (get_done(which) === 1'b1) begin
        cyc = c;
        break;
      end
      if (get_res(which) !== hold) hold_ok = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input int which, input logic [1:0] m,
                        input logic [7:0] d, input logic [7:0] s,
                        input logic [7:0] exp_res, input int exp_cyc);
    int   cyc;
    logic bok, hok;
    logic [7:0] hold;
    hold = (which == 4) ? last4 : last1;
    start_op(which, m, d, s);
    wait_done(which, hold, cyc, bok, hok);
    chk({tag, "_cycle"}, cyc, exp_cyc);
    chk({tag, "_result"}, get_res(which), exp_res);
    chk({tag, "_busy"}, bok, 1'b1);
    chk({tag, "_hold"}, hok, 1'b1);
    @(negedge clk);
    chk({tag, "_idle"}, {get_busy(which), get_done(which)}, 2'b00);
    if (which == 4) last4 = exp_res; else last1 = exp_res;
  endtask

  initial begin
    int   cyc, pulses;
    logic bok, hok;
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
    mode = SLL; din = 8'h00; shamt = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_done1", done1, 1'b0);
    chk("rst_res1", res1, 8'h00);
    chk("rst_busy4", busy4, 1'b0);
    chk("rst_done4", done4, 1'b0);
    chk("rst_res4", res4, 8'h00);

    // STEP=1
    run_op("srl_b4_3",   1, SRL, 8'hB4, 8'd3,   8'h16, 4);
    run_op("sra_96_2",   1, SRA, 8'h96, 8'd2,   8'hE5, 3);
    run_op("sra_96_200", 1, SRA, 8'h96, 8'd200, 8'hFF, 9);
    run_op("ror_81_9",   1, ROR, 8'h81, 8'd9,   8'hC0, 2);
    run_op("sll_0f_0",   1, SLL, 8'h0F, 8'd0,   8'h0F, 1);
    run_op("sll_0f_8",   1, SLL, 8'h0F, 8'd8,   8'h00, 9);
    run_op("ror_3c_8",   1, ROR, 8'h3C, 8'd8,   8'h3C, 1);

    // STEP=4
    run_op("s4_srl_f0_5", 4, SRL, 8'hF0, 8'd5, 8'h07, 3);
    run_op("s4_sll_01_8", 4, SLL, 8'h01, 8'd8, 8'h00, 3);
    run_op("s4_sra_80_7", 4, SRA, 8'h80, 8'd7, 8'hFF, 3);
    run_op("s4_ror_12_3", 4, ROR, 8'h12, 8'd3, 8'h42, 2);

    // START held high through SHIFT and DONE_S with other operands: ignored
    // until the cycle after DONE, where it is accepted.
    start_op(1, SRL, 8'hB4, 8'd3);
    start1 = 1'b1; mode = SLL; din = 8'h55; shamt = 8'd1;
    wait_done(1, last1, cyc, bok, hok);
    chk("ign_cycle", cyc, 4);
    chk("ign_result", res1, 8'h16);
    chk("ign_busy", bok, 1'b1);
    chk("ign_hold", hok, 1'b1);
    last1 = 8'h16;
    @(negedge clk);
    chk("ign_after_done", {busy1, done1}, 2'b00);
    @(posedge clk);
    #1 start1 = 1'b0;
    wait_done(1, last1, cyc, bok, hok);
    chk("b2b_cycle", cyc, 2);
    chk("b2b_result", res1, 8'hAA);
    chk("b2b_hold", hok, 1'b1);
    @(negedge clk);
    last1 = 8'hAA;
    chk("b2b_single_done", done1, 1'b0);

    // Reset mid-operation abandons it with no DONE.
    start_op(1, SRL, 8'hFF, 8'd7);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy1, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy1, 1'b0);
    chk("mid_rst_done", done1, 1'b0);
    chk("mid_rst_res", res1, 8'h00);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done1 === 1'b1) pulses++;
    end
    chk("mid_rst_no_done", pulses, 0);
    last1 = 8'h00;
    run_op("post_rst_srl_ff_7", 1, SRL, 8'hFF, 8'd7, 8'h01, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_shift_unit.md
Name: multicycle_shift_unit

Overview:
Parametrised iterative shift/rotate unit. It is the next generation of the datapath's fixed 8-bit logical right shifter and adds four modes, configurable width, configurable bits-per-cycle and a START/BUSY/DONE handshake. It sits beside the ALU. The control unit stalls the pipeline while BUSY=1 and captures RESULT when DONE=1.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a power of 2, 2..64.
- SHW, 8, width of the shift-amount input.
- STEP, 1, maximum bits shifted per cycle; must be 1, 2 or 4, and STEP <= WIDTH.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- MODE  input  2  00=SLL, 01=SRL, 10=SRA, 11=ROR; sampled with START.
- DATA_IN  input  WIDTH  operand; sampled with START.
- SHAMT  input  SHW  unsigned shift amount; sampled with START.
- BUSY  output  1  high while state != IDLE.
- DONE  output  1  one-cycle pulse; RESULT is valid.
- RESULT  output  WIDTH  shifted value; held until the next DONE.

Behaviour:
- Reset: when RESET=1 at a rising CLK edge, the unit goes to state IDLE, clears internal data and count, and drives BUSY=0, DONE=0, RESULT=0. RESET has priority over everything, including mid-operation; the operation is abandoned and no DONE is issued.
- States:
  - IDLE: START=1 latches DATA_IN, MODE and the effective count n. Next state is DONE_S if n=0, otherwise SHIFT.
  - SHIFT: each cycle applies k = min(count, STEP) bit positions in the latched mode and sets count -= k. When the new count is 0, next state is DONE_S.
  - DONE_S: RESULT is loaded from the working register and DONE=1 for exactly this cycle. Next state is IDLE unconditionally.
- Effective count n:
  - SLL/SRL/SRA: n = min(SHAMT, WIDTH). This saturates: SLL/SRL with SHAMT >= WIDTH gives 0; SRA gives all sign bits.
  - ROR: n = SHAMT mod WIDTH, i.e. the low log2(WIDTH) bits of SHAMT.
- Per-step operations:
  - SLL fills zeros at the LSB.
  - SRL fills zeros at the MSB.
  - SRA replicates the latched bit WIDTH-1.
  - ROR moves the bits shifted out of the LSB into the MSB.
- Latency: with the START-accepted cycle as cycle 0, DONE is high in cycle ceil(n/STEP)+1. The minimum is cycle 1 (n=0).
- Throughput: after DONE_S the unit returns to IDLE, so the earliest next START is accepted in the cycle after DONE.
- START while BUSY=1, including during DONE_S, is ignored: no queuing, no error, no change to the latched operands.
- Inputs: MODE, DATA_IN and SHAMT may change freely after the START cycle without affecting the operation.
- RESULT changes only on entry to DONE_S or on reset. It is stable at all other times, including while a new operation is in SHIFT.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, STEP=1, SRL 0xB4 by 3 -> RESULT=0x16, DONE high in cycle 4, BUSY high in cycles 1-4.
- SRA 0x96 by 2 -> RESULT=0xE5, DONE in cycle 3. SRA 0x96 by 200 -> RESULT=0xFF, DONE in cycle 9.
- ROR 0x81 by 9 -> RESULT=0xC0, DONE in cycle 2. SLL 0x0F by 0 -> RESULT=0x0F, DONE in cycle 1.
- STEP=4, SRL 0xF0 by 5 -> RESULT=0x07, DONE in cycle 3. SLL 0x01 by 8 -> RESULT=0x00, DONE in cycle 3.
- Second START during SHIFT with a different DATA_IN -> ignored; the first result is unchanged and exactly one DONE pulse occurs. A START in the cycle after DONE is accepted.
- RESET asserted during SHIFT of SRL 0xFF by 7 -> next cycle BUSY=0, DONE=0, RESULT=0x00, and no DONE follows. A new START then completes normally.
